// File: rtl/dart_launcher.sv
`default_nettype none
// ============================================================================
// Module   : dart_launcher
// Purpose  : Throw generator for the dart scorer. Throws come from an LFSR
//            (autoplay) or from a host aim channel; tracks turns, stops on
//            game set, throw cap or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dart_launcher #(
    parameter int GAP        = 2,
    parameter int TIMEOUT    = 16,
    parameter int MAX_THROWS = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic [15:0] seed_i,
    input  logic        aim_valid_i,
    input  logic [7:0]  aim_x_i,
    input  logic [7:0]  aim_y_i,
    output logic        aim_ready_o,
    output logic        dart_come_o,
    output logic [7:0]  dart_position_x_o,
    output logic [7:0]  dart_position_y_o,
    input  logic        player_1_done_i,
    input  logic        player_2_done_i,
    input  logic        game_set_i,
    input  logic        player_1_win_i,
    input  logic        player_2_win_i,
    output logic        busy_o,
    output logic [7:0]  throw_count_o,
    output logic [1:0]  winner_o,
    output logic        protocol_err_o,
    output logic        timeout_err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_AIM  = 3'd2;
    localparam logic [2:0] S_FIRE = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_STOP = 3'd5;

    localparam logic [15:0] c_seed_default = 16'hACE1;
    localparam logic [3:0]  c_gap          = 4'(GAP);
    // The wait counter expires on its 1 -> 0 step, giving TIMEOUT cycles from the strobe.
    localparam logic [7:0]  c_tmo_load     = 8'(TIMEOUT - 1);
    localparam logic [7:0]  c_max_throws   = 8'(MAX_THROWS);
    localparam logic [7:0]  c_coord_max    = 8'd30;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_mode;
    logic [15:0] r_lfsr;
    logic [3:0]  r_gap;
    logic [7:0]  r_tmo;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic        r_turn;
    logic [1:0]  r_throw_in_turn;
    logic [7:0]  r_count;
    logic [1:0]  r_winner;
    logic        r_protocol_err;
    logic        r_timeout_err;

    logic        w_any_done;
    logic        w_unexp_done;
    logic [7:0]  w_count_inc;
    logic        w_tmo_expire;
    logic [15:0] w_lfsr_next;
    logic [7:0]  w_lfsr_x;
    logic [7:0]  w_lfsr_y;
    logic [7:0]  w_aim_x;
    logic [7:0]  w_aim_y;

    assign w_any_done   = player_1_done_i | player_2_done_i;
    // Both dones together always include the wrong player's, so count as a protocol error.
    assign w_unexp_done = r_turn ? player_1_done_i : player_2_done_i;
    assign w_count_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
    assign w_tmo_expire = (r_tmo == 8'd1);
    assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_lfsr_x     = (r_lfsr[4:0] == 5'd31) ? 8'd15 : {3'd0, r_lfsr[4:0]};
    assign w_lfsr_y     = (r_lfsr[9:5] == 5'd31) ? 8'd15 : {3'd0, r_lfsr[9:5]};
    assign w_aim_x      = (aim_x_i > c_coord_max) ? c_coord_max : aim_x_i;
    assign w_aim_y      = (aim_y_i > c_coord_max) ? c_coord_max : aim_y_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next_state = S_GAP;
            S_GAP:  if (r_gap == 4'd1) w_next_state = r_mode ? S_AIM : S_FIRE;
            S_AIM:  if (aim_valid_i) w_next_state = S_FIRE;
            S_FIRE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_any_done) begin
                    if (game_set_i)                       w_next_state = S_STOP;
                    else if (w_count_inc == c_max_throws) w_next_state = S_STOP;
                    else                                  w_next_state = S_GAP;
                end else if (game_set_i || w_tmo_expire) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: if (!start_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        aim_ready_o = 1'b0;
        dart_come_o = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_AIM:   aim_ready_o = 1'b1;
            S_FIRE:  dart_come_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode          <= 1'b0;
            r_lfsr          <= c_seed_default;
            r_gap           <= 4'd0;
            r_tmo           <= 8'd0;
            r_x             <= 8'd0;
            r_y             <= 8'd0;
            r_turn          <= 1'b0;
            r_throw_in_turn <= 2'd0;
            r_count         <= 8'd0;
            r_winner        <= 2'b00;
            r_protocol_err  <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode          <= mode_i;
                        r_lfsr          <= (seed_i == 16'd0) ? c_seed_default : seed_i;
                        r_gap           <= c_gap;
                        r_turn          <= 1'b0;
                        r_throw_in_turn <= 2'd0;
                        r_count         <= 8'd0;
                        r_winner        <= 2'b00;
                        r_protocol_err  <= 1'b0;
                        r_timeout_err   <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 4'd1;
                    // Autoplay coordinates are loaded ahead of the strobe so they are valid with it.
                    if (r_gap == 4'd1 && !r_mode) begin
                        r_x <= w_lfsr_x;
                        r_y <= w_lfsr_y;
                    end
                end
                S_AIM: begin
                    if (aim_valid_i) begin
                        r_x <= w_aim_x;
                        r_y <= w_aim_y;
                    end
                end
                S_FIRE: begin
                    r_tmo <= c_tmo_load;
                    if (!r_mode) r_lfsr <= w_lfsr_next;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo - 8'd1;
                    r_gap <= c_gap;
                    if (w_any_done) begin
                        r_count <= w_count_inc;
                        if (w_unexp_done) r_protocol_err <= 1'b1;
                        if (r_throw_in_turn == 2'd2) begin
                            r_throw_in_turn <= 2'd0;
                            r_turn          <= ~r_turn;
                        end else begin
                            r_throw_in_turn <= r_throw_in_turn + 2'd1;
                        end
                    end
                    if (game_set_i) begin
                        r_winner <= {player_2_win_i, player_1_win_i};
                    end else if (!w_any_done && w_tmo_expire) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dart_position_x_o = r_x;
    assign dart_position_y_o = r_y;
    assign throw_count_o     = r_count;
    assign winner_o          = r_winner;
    assign protocol_err_o    = r_protocol_err;
    assign timeout_err_o     = r_timeout_err;

endmodule
`default_nettype wire
